// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per cycle, result WIDTH+1 cycles after accept.
// Optional macro DIVZERO_DETECT_EN adds div_by_zero and a one-cycle shortcut for a zero divisor.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVZERO_DETECT_EN
  ,
  output logic             div_by_zero
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   r_shift, trial;
  logic             skip;
`ifdef DIVZERO_DETECT_EN
  logic             dz_q, dz_d;
  logic             dzo_q, dzo_d;
  assign skip        = dz_q;
  assign div_by_zero = dzo_q;
`else
  assign skip        = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Trial subtraction; the top bit of trial is the borrow.
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, d_q};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIVZERO_DETECT_EN
    dz_d    = dz_q;
    dzo_d   = dzo_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
`ifdef DIVZERO_DETECT_EN
          dz_d    = (divisor == '0);
`endif
        end
      end
      RUN: begin
        if (skip) begin
          // Q still holds the untouched dividend here.
          state_d = DONE;
          quo_d   = '1;
          rem_d   = q_q;
`ifdef DIVZERO_DETECT_EN
          dzo_d   = 1'b1;
`endif
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d = DONE;
          quo_d   = q_q;
          rem_d   = r_q[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!trial[WIDTH]) begin
            r_d = trial;
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = r_shift;
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef DIVZERO_DETECT_EN
          dzo_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIVZERO_DETECT_EN
      dz_q    <= 1'b0;
      dzo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIVZERO_DETECT_EN
      dz_q    <= dz_d;
      dzo_q   <= dzo_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed corner cases, full operand sweep and random ops vs. an arithmetic model.
module tb_seq_restoring_divider;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] quotient, remainder;
`ifdef DIVZERO_DETECT_EN
  logic         div_by_zero;
`endif

  int checks = 0;
  int errors = 0;
  int prev_q = 0;
  int prev_r = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
`ifdef DIVZERO_DETECT_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic run_op(input int a, input int b, input int stall);
    int lat;
    int exp_lat;
    int eq;
    int er;
    eq      = ref_q(a, b);
    er      = ref_r(a, b);
    exp_lat = W + 1;
`ifdef DIVZERO_DETECT_EN
    if (b == 0) exp_lat = 1;
`endif
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = W'(a);
    divisor   = W'(b);
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    chk("hold_q_run", quotient, prev_q);
    chk("hold_r_run", remainder, prev_r);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_q", quotient, eq);
      chk("stall_r", remainder, er);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("out_valid", out_valid, 1);
`ifdef DIVZERO_DETECT_EN
    chk("div_by_zero", div_by_zero, (b == 0));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
`ifdef DIVZERO_DETECT_EN
    chk("div_by_zero_clear", div_by_zero, 0);
`endif
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin : main
    int qa[$];
    int qb[$];
    int acc;
    int res;
    int cyc;
    int a;
    int b;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
`ifdef DIVZERO_DETECT_EN
    chk("rst_div_by_zero", div_by_zero, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corners
    run_op(13, 3, 0);
    run_op(15, 15, 0);
    run_op(7, 9, 0);
    run_op(9, 0, 0);
    run_op(6, 2, 6);

    // Reset in the second RUN cycle discards the op
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = 4'd14;
    divisor   = 4'd5;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_in_ready", in_ready, 1);
    prev_q = 0;
    prev_r = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(11, 4, 0);

    // Full sweep with random consumer stalls
    for (int x = 0; x <= MAXV; x++)
      for (int y = 1; y <= MAXV; y++)
        run_op(x, y, $urandom_range(0, 2));

    // in_valid held high with operands changing every cycle
    acc = 0;
    res = 0;
    cyc = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while ((acc < 2 || res < 2) && cyc < 100) begin
      if (out_valid) begin
        if (qa.size() == 0) begin
          chk("hold_spurious_result", out_valid, 0);
        end else begin
          a = qa.pop_front();
          b = qb.pop_front();
          chk("hold_quotient", quotient, ref_q(a, b));
          chk("hold_remainder", remainder, ref_r(a, b));
          prev_q = ref_q(a, b);
          prev_r = ref_r(a, b);
          res++;
        end
      end
      if (acc < 2) begin
        in_valid = 1'b1;
        dividend = W'($urandom_range(0, MAXV));
        divisor  = W'($urandom_range(1, MAXV));
        if (in_ready) begin
          qa.push_back(int'(dividend));
          qb.push_back(int'(divisor));
          acc++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("hold_result_count", res, 2);
    chk("hold_accept_count", acc, 2);

    // Random ops, zero divisor allowed
    for (int k = 0; k < 30; k++)
      run_op($urandom_range(0, MAXV), $urandom_range(0, MAXV), $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
